apb_slv_regfile: RTL and testbench

APB slave register file that sits directly downstream of the team's APB master and answers its SETUP/ACCESS transfers. It holds 16 word registers at a configurable base address and inserts a parameterised number of wait states via pready. It flags out-of-range or illegal accesses with pslverr. Register 0 is a read-only ID; registers 1-15 are read/write storage.

---
 rtl/apb_slv_regfile_pkg.sv | 13 +
 rtl/apb_slv_regfile_if.sv | 23 ++
 rtl/apb_slv_regfile_wait_ctr.sv | 23 ++
 rtl/apb_slv_regfile.sv | 88 ++++++++
 tb/tb_apb_slv_regfile.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/apb_slv_regfile_pkg.sv
// Shared types and widths for the APB register-file slave.
// Bus widths, register index width and FSM state encoding.
package apb_pkg;
    localparam int APB_AW    = 32;
    localparam int APB_DW    = 32;
    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;
endpackage

// File: rtl/apb_slv_regfile_if.sv
// APB bus bundle between the master and the register-file slave.
interface apb_slv_regfile_if;
    import apb_pkg::*;

    logic              psel;
    logic              penable;
    logic [APB_AW-1:0] paddr;
    logic              pwrite;
    logic [APB_DW-1:0] pwdata;
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slv_regfile_wait_ctr.sv
// 4-bit load/decrement counter that paces the access-phase wait states.
module apb_wait_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);
endmodule

// File: rtl/apb_slv_regfile.sv
// APB slave with 16 word registers (reg 0 = read-only ID) and a fixed
// number of pready wait states per transfer; errors reported on pslverr.
module apb_slv_regfile
    import apb_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'hDEADCAC0,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [APB_DW-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic               clk,
    input  logic               rst,
    apb_slv_regfile_if.slave   apb
);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    apb_state_t                         r_state;
    apb_state_t                         w_nstate;
    logic [NUM_REGS-1:0][APB_DW-1:0]    r_regs;
    logic                               w_load;
    logic                               w_dec;
    logic                               w_zero;
    logic                               w_ready;
    logic                               w_hit;
    logic                               w_err;
    logic [REG_IDX_W-1:0]               w_idx;
    logic                               w_unused;

    assign w_hit    = (apb.paddr[APB_AW-1:6] == BASE_ADDR[APB_AW-1:6]);
    assign w_idx    = apb.paddr[5:2];
    assign w_err    = !w_hit || (apb.pwrite && (w_idx == '0));
    assign w_unused = ^apb.paddr[1:0];

    apb_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (LP_WAIT),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // penable without a preceding setup is a protocol error and is ignored
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            ST_IDLE:   if (apb.psel && !apb.penable) w_nstate = ST_ACCESS;
            ST_ACCESS: if (!apb.psel || w_zero)      w_nstate = ST_IDLE;
            default:   w_nstate = ST_IDLE;
        endcase
    end

    // rst gating keeps the bus quiet in the cycle a reset aborts a transfer
    always_comb begin
        w_load  = 1'b0;
        w_dec   = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:   w_load  = apb.psel && !apb.penable;
            ST_ACCESS: begin
                w_dec   = apb.psel && !w_zero;
                w_ready = apb.psel && w_zero && !rst;
            end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '0;
        end else if (w_ready && apb.pwrite && !w_err) begin
            r_regs[w_idx] <= apb.pwdata;
        end
    end

    assign apb.pready  = w_ready;
    assign apb.pslverr = w_ready && w_err;
    assign apb.prdata  = (w_ready && !apb.pwrite && !w_err)
                       ? ((w_idx == '0) ? ID_VALUE : r_regs[w_idx])
                       : '0;
endmodule

// File: tb/tb_apb_slv_regfile.sv
// Directed vector bench for apb_slv_regfile across three wait-state settings.
module tb_apb_slv_regfile;
    import apb_pkg::*;

    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 16;
    int waits_of [3] = '{2, 3, 0};

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    int          sel;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] m_prdata;
    logic        m_pready, m_pslverr;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vt [NV];

    always #5 clk = ~clk;

    apb_slv_regfile_if b0 ();
    apb_slv_regfile_if b1 ();
    apb_slv_regfile_if b2 ();

    assign b0.psel = psel && (sel == 0);
    assign b1.psel = psel && (sel == 1);
    assign b2.psel = psel && (sel == 2);
    assign b0.penable = penable; assign b1.penable = penable; assign b2.penable = penable;
    assign b0.paddr   = paddr;   assign b1.paddr   = paddr;   assign b2.paddr   = paddr;
    assign b0.pwrite  = pwrite;  assign b1.pwrite  = pwrite;  assign b2.pwrite  = pwrite;
    assign b0.pwdata  = pwdata;  assign b1.pwdata  = pwdata;  assign b2.pwdata  = pwdata;

    apb_slv_regfile #(.WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst_v[0]), .apb(b0.slave));
    apb_slv_regfile #(.WAIT_CYCLES(3)) dut1 (.clk(clk), .rst(rst_v[1]), .apb(b1.slave));
    apb_slv_regfile #(.WAIT_CYCLES(0)) dut2 (.clk(clk), .rst(rst_v[2]), .apb(b2.slave));

    always_comb begin
        case (sel)
            1:       begin m_prdata = b1.prdata; m_pready = b1.pready; m_pslverr = b1.pslverr; end
            2:       begin m_prdata = b2.prdata; m_pready = b2.pready; m_pslverr = b2.pslverr; end
            default: begin m_prdata = b0.prdata; m_pready = b0.pready; m_pslverr = b0.pslverr; end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+#1; drives setup now, returns at posedge+#1 after the
    // pready cycle so the next call issues its setup back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int nw);
        bit done;
        sel = d; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        nw = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (m_pready) begin
                done = 1;
            end else if (nw >= 20) begin
                done = 1;
                nw = -1;
            end else begin
                nw++;
                @(posedge clk); #1;
            end
        end
        rd = m_prdata; er = m_pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run_check(input string name, input int d, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          nw;
        xfer(d, wr, a, wd, rd, er, nw);
        chk({name, " waits"}, 32'(nw), 32'(waits_of[d]));
        chk({name, " prdata"}, rd, exp_rd);
        chk({name, " pslverr"}, {31'd0, er}, {31'd0, exp_er});
    endtask

    function automatic vec_t mk(int d, logic wr, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic er);
        vec_t v;
        v.dut = d; v.wr = wr; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
        return v;
    endfunction

    initial begin
        vt[0]  = mk(0, 1, 32'hDEADCAC4, 32'h12345678, 32'h0,        0);
        vt[1]  = mk(0, 0, 32'hDEADCAC4, 32'h0,        32'h12345678, 0);
        vt[2]  = mk(0, 1, 32'hDEADCAFE, 32'h00000041, 32'h0,        0);
        vt[3]  = mk(0, 0, 32'hDEADCAFE, 32'h0,        32'h00000041, 0);
        vt[4]  = mk(0, 1, 32'hDEADCAFE, 32'h00000042, 32'h0,        0);
        vt[5]  = mk(0, 0, 32'hDEADCAFE, 32'h0,        32'h00000042, 0);
        vt[6]  = mk(0, 0, 32'h00000000, 32'h0,        32'h0,        1);
        vt[7]  = mk(0, 1, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1);
        vt[8]  = mk(0, 1, 32'hDEADCAC0, 32'hFFFFFFFF, 32'h0,        1);
        vt[9]  = mk(0, 0, 32'hDEADCAC0, 32'h0,        32'hA9B00001, 0);
        vt[10] = mk(0, 0, 32'hDEADCAC7, 32'h0,        32'h12345678, 0);
        vt[11] = mk(0, 0, 32'hDEADCB00, 32'h0,        32'h0,        1);
        vt[12] = mk(0, 0, 32'hDEADCAFE, 32'h0,        32'h00000042, 0);
        vt[13] = mk(2, 1, 32'hDEADCAD0, 32'hAAAA5555, 32'h0,        0);
        vt[14] = mk(2, 0, 32'hDEADCAD0, 32'h0,        32'hAAAA5555, 0);
        vt[15] = mk(2, 1, 32'hDEADCAC0, 32'h00000001, 32'h0,        1);

        // Reset with a setup+access attempt on the bus: outputs must stay 0.
        rst_v = 3'b111; sel = 0;
        psel = 1'b1; penable = 1'b0; paddr = 32'hDEADCAC4; pwrite = 1'b0; pwdata = '0;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst pready", {31'd0, m_pready}, 32'd0);
        chk("rst pslverr", {31'd0, m_pslverr}, 32'd0);
        chk("rst prdata", m_prdata, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rst_v = 3'b000;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_check($sformatf("vec%0d", i), vt[i].dut, vt[i].wr, vt[i].addr,
                      vt[i].wdata, vt[i].rdata, vt[i].err);
        end

        // psel dropped in the first access cycle: no write, FSM back in IDLE.
        sel = 0; psel = 1'b1; penable = 1'b0;
        paddr = 32'hDEADCAC8; pwrite = 1'b1; pwdata = 32'h13579BDF;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        chk("abort pready", {31'd0, m_pready}, 32'd0);
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        run_check("abort readback", 0, 0, 32'hDEADCAC8, 32'h0, 32'h0, 0);
        run_check("after abort wr", 0, 1, 32'hDEADCACC, 32'h0BADF00D, 32'h0, 0);
        run_check("after abort rd", 0, 0, 32'hDEADCACC, 32'h0, 32'h0BADF00D, 0);

        // Reset in the 2nd access cycle of a WAIT_CYCLES=3 write.
        run_check("pre-rst wr", 1, 1, 32'hDEADCAC8, 32'hCAFEF00D, 32'h0, 0);
        run_check("pre-rst rd", 1, 0, 32'hDEADCAC8, 32'h0, 32'hCAFEF00D, 0);
        sel = 1; psel = 1'b1; penable = 1'b0;
        paddr = 32'hDEADCAC8; pwrite = 1'b1; pwdata = 32'h11111111;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        chk("midrst acc1 pready", {31'd0, m_pready}, 32'd0);
        @(posedge clk); #1; rst_v[1] = 1'b1;
        @(negedge clk);
        chk("midrst acc2 pready", {31'd0, m_pready}, 32'd0);
        chk("midrst acc2 pslverr", {31'd0, m_pslverr}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst held pready", {31'd0, m_pready}, 32'd0);
        chk("midrst held prdata", m_prdata, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rst_v[1] = 1'b0;
        @(posedge clk); #1;
        run_check("post-rst rd", 1, 0, 32'hDEADCAC8, 32'h0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
